// File: rtl/reg_file_write_bank.sv
// ---------------------------------------------------------------------------
// reg_file_write_bank
//
// Purpose
//   Write side of the 32-entry datapath register file, plus its two
//   combinational read ports. A 5-to-32 one-hot write decoder drives 31
//   storage registers (X0..X30) of n bits each. X31 is the zero register
//   (XZR): it has no storage, ignores writes and always reads 0.
//   A read port whose address matches an in-flight write (WE=1, WA==RAx,
//   WA!=31) forwards WD in the same cycle. This lets write-back and decode
//   share a cycle without a hazard.
//
// Ports
//   clock  in   1   rising-edge clock for all storage
//   reset  in   1   asynchronous, active-high; clears X0..X30
//   WE     in   1   write enable (RegWrite)
//   WA     in   5   write address (Rd)
//   WD     in   n   write data (write-back result)
//   RA1    in   5   read address, port 1 (Rn)
//   RA2    in   5   read address, port 2 (Rm/Rt)
//   RD1    out  n   read data, port 1
//   RD2    out  n   read data, port 2
// ---------------------------------------------------------------------------

// One storage register of the bank. It loads d_i on a clock edge when
// wen_i is set and clears asynchronously on reset.
module reg_file_write_bank_cell #(
    parameter int n = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wen_i,
    input  logic [n-1:0] d_i,
    output logic [n-1:0] q_o
);

    logic [n-1:0] r_q;
    logic [n-1:0] r_d;

    always_comb begin
        r_d = r_q;
        if (wen_i) r_d = d_i;
    end

    // Reset has priority over the clock. A write on an edge where reset
    // is also high is therefore dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_q <= '0;
        else       r_q <= r_d;
    end

    assign q_o = r_q;

endmodule

module reg_file_write_bank #(
    parameter int n = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         WE,
    input  logic [4:0]   WA,
    input  logic [n-1:0] WD,
    input  logic [4:0]   RA1,
    input  logic [4:0]   RA2,
    output logic [n-1:0] RD1,
    output logic [n-1:0] RD2
);

    localparam logic [4:0] XZR = 5'h1F;

    logic [31:0]  wen;
    logic [n-1:0] bank [32];
    logic         fwd1;
    logic         fwd2;

    // Write decoder. The shift is evaluated only under WE, so an X or Z
    // address with WE=0 still yields an all-zero enable vector. XZR's
    // enable is forced off.
    always_comb begin
        wen = '0;
        if (WE) wen = 32'b1 << WA;
        wen[31] = 1'b0;
    end

    genvar k;
    generate
        for (k = 0; k < 31; k++) begin : g_reg
            reg_file_write_bank_cell #(.n(n)) u_cell (
                .clock (clock),
                .reset (reset),
                .wen_i (wen[k]),
                .d_i   (WD),
                .q_o   (bank[k])
            );
        end
    endgenerate

    // XZR has no storage. Tying its slot to zero lets the read mux stay a
    // plain 32:1 select.
    assign bank[31] = '0;

    // Forwarding is suppressed during reset, because writes are ignored
    // then. The bank is already clear, so both ports read 0.
    assign fwd1 = WE && !reset && (WA == RA1) && (WA != XZR);
    assign fwd2 = WE && !reset && (WA == RA2) && (WA != XZR);

    always_comb begin
        RD1 = bank[RA1];
        if (fwd1)  RD1 = WD;
        if (reset) RD1 = '0;
    end

    always_comb begin
        RD2 = bank[RA2];
        if (fwd2)  RD2 = WD;
        if (reset) RD2 = '0;
    end

endmodule
